// File: rtl/nes_cpu_bus.sv
// nes_cpu_bus: CPU-side bus responder for the NES core.
//   Decodes every CPU bus cycle, serves the 2 KB internal work RAM (mirrored
//   across $0000-$1FFF), forwards the $2000-$3FFF window to the PPU register
//   port, and runs the OAM DMA engine triggered by a write to DMA_REG_ADDR.
//
// Ports:
//   clk        system clock, one CPU bus cycle per clock
//   rst        asynchronous active-low reset
//   addr       CPU address
//   d_out      CPU write data
//   we         CPU write strobe (1 = write, 0 = read)
//   d_in       registered read data to CPU, valid the cycle after the read
//   cpu_halt   stall request; high while DMA owns the bus
//   ppu_addr   PPU register index
//   ppu_wdata  PPU write data
//   ppu_wr     single-cycle PPU write strobe
//   ppu_rd     single-cycle PPU read strobe
//   ppu_rdata  PPU read data, combinational in the ppu_rd cycle
//
// Build option:
//   OPEN_BUS_EN  when defined, unmapped reads (CPU and DMA) return the
//                open-bus latch instead of 8'h00.
module nes_cpu_bus #(
  parameter int          RAM_ADDR_W   = 11,
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_REG_IDX  = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_out,
  input  logic        we,
  output logic [7:0]  d_in,
  output logic        cpu_halt,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_wr,
  output logic        ppu_rd,
  input  logic [7:0]  ppu_rdata
);

  localparam int RAM_DEPTH = 2 ** RAM_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DRD   = 2'd2,
    ST_DWR   = 2'd3
  } dma_state_t;

  dma_state_t            state_r;
  dma_state_t            state_s;
  logic [7:0]            page_r;
  logic [7:0]            idx_r;
  logic [7:0]            dma_data_r;
  logic [7:0]            d_in_r;
  logic                  align_extra_r;
  logic                  parity_r;
  logic                  halt_r;
  logic [7:0]            ram_r [RAM_DEPTH];

  logic                  cpu_ok_s;
  logic                  sel_ram_s;
  logic                  sel_ppu_s;
  logic                  sel_dma_s;
  logic [15:0]           dma_src_s;
  logic [15:0]           ram_rd_full_s;
  logic [RAM_ADDR_W-1:0] ram_rd_addr_s;
  logic [RAM_ADDR_W-1:0] ram_wr_addr_s;
  logic [7:0]            ram_rdata_s;
  logic [7:0]            unmapped_s;
  logic [7:0]            cpu_rd_data_s;
  logic [7:0]            dma_rd_data_s;
  logic                  ram_we_s;
  logic                  trigger_s;
  logic                  ppu_wr_s;
  logic                  ppu_rd_s;
  logic [2:0]            ppu_addr_s;
  logic [7:0]            ppu_wdata_s;
  logic                  unused_ok_s;

  // The CPU only owns the bus out of reset and while no DMA is running.
  assign cpu_ok_s  = rst && (state_r == ST_IDLE);
  assign sel_ram_s = (addr[15:13] == 3'b000);
  assign sel_ppu_s = (addr[15:13] == 3'b001);
  assign sel_dma_s = (addr == DMA_REG_ADDR);

  // One RAM read port shared by the CPU and the DMA read phase.
  assign dma_src_s     = {page_r, idx_r};
  assign ram_rd_full_s = (state_r == ST_DRD) ? dma_src_s : addr;
  assign ram_rd_addr_s = ram_rd_full_s[RAM_ADDR_W-1:0];
  assign ram_wr_addr_s = addr[RAM_ADDR_W-1:0];
  assign ram_rdata_s   = ram_r[ram_rd_addr_s];
  assign unused_ok_s   = ^ram_rd_full_s;

`ifdef OPEN_BUS_EN
  logic [7:0] open_bus_r;

  // Open-bus latch: last byte the CPU saw on the data bus (read or written).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      open_bus_r <= 8'h00;
    end else if (cpu_ok_s) begin
      if (we) begin
        open_bus_r <= d_out;
      end else begin
        open_bus_r <= cpu_rd_data_s;
      end
    end
  end

  assign unmapped_s = open_bus_r;
`else
  assign unmapped_s = 8'h00;
`endif

  // Address decode, PPU strobes and DMA next-state.
  always_comb begin
    state_s       = state_r;
    ram_we_s      = 1'b0;
    trigger_s     = 1'b0;
    ppu_wr_s      = 1'b0;
    ppu_rd_s      = 1'b0;
    ppu_addr_s    = 3'd0;
    ppu_wdata_s   = 8'h00;
    cpu_rd_data_s = unmapped_s;
    dma_rd_data_s = unmapped_s;
    case (state_r)
      ST_IDLE: begin
        if (!cpu_ok_s) begin
          state_s = ST_IDLE;
        end else if (we) begin
          if (sel_ram_s) begin
            ram_we_s = 1'b1;
          end else if (sel_ppu_s) begin
            ppu_wr_s    = 1'b1;
            ppu_addr_s  = addr[2:0];
            ppu_wdata_s = d_out;
          end else if (sel_dma_s) begin
            // The trigger write itself goes nowhere else.
            trigger_s = 1'b1;
            state_s   = ST_ALIGN;
          end else begin
            ram_we_s = 1'b0;
          end
        end else begin
          if (sel_ram_s) begin
            cpu_rd_data_s = ram_rdata_s;
          end else if (sel_ppu_s) begin
            ppu_rd_s      = 1'b1;
            ppu_addr_s    = addr[2:0];
            cpu_rd_data_s = ppu_rdata;
          end else begin
            cpu_rd_data_s = unmapped_s;
          end
        end
      end
      ST_ALIGN: begin
        // An odd trigger cycle costs one extra alignment cycle.
        if (align_extra_r) begin
          state_s = ST_ALIGN;
        end else begin
          state_s = ST_DRD;
        end
      end
      ST_DRD: begin
        // Non-RAM pages never touch the PPU during DMA reads.
        if (dma_src_s[15:13] == 3'b000) begin
          dma_rd_data_s = ram_rdata_s;
        end else begin
          dma_rd_data_s = unmapped_s;
        end
        state_s = ST_DWR;
      end
      ST_DWR: begin
        ppu_wr_s    = 1'b1;
        ppu_addr_s  = OAM_REG_IDX;
        ppu_wdata_s = dma_data_r;
        if (idx_r == 8'hFF) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, halt flag and free-running cycle parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      halt_r   <= 1'b0;
      parity_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      halt_r   <= (state_s != ST_IDLE);
      parity_r <= ~parity_r;
    end
  end

  // DMA page, byte index, alignment flag and held data byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page_r        <= 8'h00;
      idx_r         <= 8'h00;
      align_extra_r <= 1'b0;
      dma_data_r    <= 8'h00;
    end else begin
      if (trigger_s) begin
        page_r        <= d_out;
        idx_r         <= 8'h00;
        align_extra_r <= parity_r;
      end
      if (state_r == ST_ALIGN) begin
        align_extra_r <= 1'b0;
      end
      if (state_r == ST_DRD) begin
        dma_data_r <= dma_rd_data_s;
      end
      if (state_r == ST_DWR) begin
        idx_r <= idx_r + 8'd1;
      end
    end
  end

  // Read data register; holds its value on writes and while halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_in_r <= 8'h00;
    end else if (cpu_ok_s && !we) begin
      d_in_r <= cpu_rd_data_s;
    end
  end

  // Work RAM storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[ram_wr_addr_s] <= d_out;
    end
  end

  assign d_in      = d_in_r;
  assign cpu_halt  = halt_r;
  assign ppu_wr    = ppu_wr_s;
  assign ppu_rd    = ppu_rd_s;
  assign ppu_addr  = ppu_addr_s;
  assign ppu_wdata = ppu_wdata_s;

endmodule

// File: tb/tb_nes_cpu_bus.sv
// tb_nes_cpu_bus: self-checking bench for nes_cpu_bus.
//   A transaction-level model (RAM array, DMA counted in cycles since the
//   trigger) predicts every output each cycle; directed tests add literal
//   expectations for RAM mirroring, PPU access, unmapped reads and DMA.
module tb_nes_cpu_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d_out = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  d_in;
  logic        cpu_halt;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_wr;
  logic        ppu_rd;
  logic [7:0]  ppu_rdata = 8'h00;

  int checks = 0;
  int errors = 0;

  nes_cpu_bus dut (
    .clk(clk), .rst(rst), .addr(addr), .d_out(d_out), .we(we),
    .d_in(d_in), .cpu_halt(cpu_halt), .ppu_addr(ppu_addr),
    .ppu_wdata(ppu_wdata), .ppu_wr(ppu_wr), .ppu_rd(ppu_rd),
    .ppu_rdata(ppu_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_ram [0:2047];
  logic       m_parity;
  logic       m_dma;
  int         m_r;
  int         m_align;
  logic [7:0] m_page;
  logic [7:0] m_d_in;
  logic [7:0] m_open_bus;

  function automatic logic [7:0] unmapped_val();
`ifdef OPEN_BUS_EN
    return m_open_bus;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] rd_val(input logic [15:0] a, input logic [7:0] prd);
    if (a < 16'h2000) return m_ram[a[10:0]];
    else if (a < 16'h4000) return prd;
    else return unmapped_val();
  endfunction

  function automatic logic [7:0] dma_src(input int k);
    logic [15:0] a;
    a = {m_page, k[7:0]};
    if (a < 16'h2000) return m_ram[a[10:0]];
    else return unmapped_val();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_parity   <= 1'b0;
      m_dma      <= 1'b0;
      m_r        <= 0;
      m_d_in     <= 8'h00;
      m_open_bus <= 8'h00;
    end else begin
      m_parity <= ~m_parity;
      if (m_dma) begin
        if (m_r == 512 + m_align) m_dma <= 1'b0;
        else m_r <= m_r + 1;
      end else if (we) begin
        m_open_bus <= d_out;
        if (addr < 16'h2000) m_ram[addr[10:0]] <= d_out;
        else if (addr == 16'h4014) begin
          m_dma   <= 1'b1;
          m_r     <= 1;
          m_align <= m_parity ? 2 : 1;
          m_page  <= d_out;
        end
      end else begin
        m_d_in     <= rd_val(addr, ppu_rdata);
        m_open_bus <= rd_val(addr, ppu_rdata);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic       e_wr;
    logic       e_rd;
    logic [2:0] e_pa;
    logic [7:0] e_pd;
    if (rst) begin
      e_wr = 1'b0; e_rd = 1'b0; e_pa = 3'd0; e_pd = 8'h00;
      if (m_dma) begin
        if (m_r > m_align && ((m_r - m_align) % 2) == 0) begin
          e_wr = 1'b1;
          e_pa = 3'd4;
          e_pd = dma_src((m_r - m_align) / 2 - 1);
        end
      end else if (addr[15:13] == 3'b001) begin
        e_pa = addr[2:0];
        if (we) begin
          e_wr = 1'b1;
          e_pd = d_out;
        end else begin
          e_rd = 1'b1;
        end
      end
      check("m_cpu_halt", cpu_halt, m_dma);
      check("m_d_in", d_in, m_d_in);
      check("m_ppu_wr", ppu_wr, e_wr);
      check("m_ppu_rd", ppu_rd, e_rd);
      if (e_wr || e_rd) check("m_ppu_addr", ppu_addr, e_pa);
      if (e_wr) check("m_ppu_wdata", ppu_wdata, e_pd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    addr = a; we = w; d_out = d;
    @(posedge clk); #1;
  endtask

  // Watch a running DMA while driving garbage CPU traffic; stop early
  // after stop_after OAM writes when stop_after is non-zero.
  task automatic dma_watch(input int stop_after, output int halt_n, output int wr_n);
    halt_n = 0;
    wr_n   = 0;
    for (int c = 0; c < 600; c++) begin
      if (!cpu_halt) break;
      halt_n++;
      addr  = c[0] ? 16'h4014 : 16'h0201;
      we    = 1'b1;
      d_out = 8'hEE;
      @(negedge clk);
      if (ppu_wr) begin
        check("dma_wdata", ppu_wdata, wr_n[7:0]);
        check("dma_oam_idx", ppu_addr, 3'd4);
        wr_n++;
      end
      @(posedge clk); #1;
      if (stop_after != 0 && wr_n == stop_after) break;
    end
    addr = 16'h6000; we = 1'b0; d_out = 8'h00;
  endtask

  task automatic run_dma(input logic [7:0] page, input logic want_odd, input int exp_len);
    int h;
    int w;
    if (m_parity != want_odd) bus(16'h6000, 1'b0, 8'h00);
    bus(16'h4014, 1'b1, page);
    dma_watch(0, h, w);
    check("dma_halt_len", h, exp_len);
    check("dma_write_count", w, 256);
    bus(16'h0201, 1'b0, 8'h00);
    check("dma_ignored_cpu_write", d_in, 8'h01);
  endtask

  initial begin
    int h;
    int w;
    int extra;
    #1;
    rst = 1'b0;
    addr = 16'h2003; we = 1'b1; d_out = 8'h77;
    #2;
    check("rst_d_in", d_in, 8'h00);
    check("rst_cpu_halt", cpu_halt, 1'b0);
    check("rst_ppu_wr", ppu_wr, 1'b0);
    check("rst_ppu_rd", ppu_rd, 1'b0);
    check("rst_ppu_addr", ppu_addr, 3'd0);
    check("rst_ppu_wdata", ppu_wdata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;

    // RAM mirroring
    bus(16'h0005, 1'b1, 8'hA5);
    bus(16'h0006, 1'b1, 8'h5A);
    bus(16'h07FA, 1'b1, 8'h55);
    bus(16'h0805, 1'b0, 8'h00);
    check("ram_mirror_0805", d_in, 8'hA5);
    bus(16'h1805, 1'b0, 8'h00);
    check("ram_mirror_1805", d_in, 8'hA5);
    bus(16'h0006, 1'b0, 8'h00);
    check("ram_0006", d_in, 8'h5A);

    // PPU write through a mirror of the register window
    addr = 16'h3FFA; we = 1'b1; d_out = 8'h12;
    #2;
    check("ppu_wr_pulse", ppu_wr, 1'b1);
    check("ppu_wr_addr", ppu_addr, 3'd2);
    check("ppu_wr_data", ppu_wdata, 8'h12);
    @(posedge clk); #1;
    addr = 16'h1FFA; we = 1'b0;
    #2;
    check("ppu_wr_one_cycle", ppu_wr, 1'b0);
    @(posedge clk); #1;
    check("ppu_wr_ram_unchanged", d_in, 8'h55);

    // PPU read
    addr = 16'h2002; we = 1'b0; ppu_rdata = 8'h80;
    #2;
    check("ppu_rd_pulse", ppu_rd, 1'b1);
    check("ppu_rd_addr", ppu_addr, 3'd2);
    check("ppu_rd_no_wr", ppu_wr, 1'b0);
    @(posedge clk); #1;
    ppu_rdata = 8'h00;
    addr = 16'h0005;
    check("ppu_rd_d_in", d_in, 8'h80);
    #2;
    check("ppu_rd_one_cycle", ppu_rd, 1'b0);
    @(posedge clk); #1;

    // Unmapped reads, including the write-only DMA register
    bus(16'h0010, 1'b1, 8'h3C);
    bus(16'h0010, 1'b0, 8'h00);
    check("ram_0010", d_in, 8'h3C);
    bus(16'h5000, 1'b0, 8'h00);
`ifdef OPEN_BUS_EN
    check("unmapped_5000", d_in, 8'h3C);
    bus(16'h4014, 1'b0, 8'h00);
    check("unmapped_4014", d_in, 8'h3C);
`else
    check("unmapped_5000", d_in, 8'h00);
    bus(16'h4014, 1'b0, 8'h00);
    check("unmapped_4014", d_in, 8'h00);
`endif
    check("read_4014_no_halt", cpu_halt, 1'b0);

    // DMA source page
    for (int i = 0; i < 256; i++) bus(16'h0200 + 16'(i), 1'b1, 8'(i));

    run_dma(8'h02, 1'b0, 513);
    run_dma(8'h0A, 1'b1, 514);

    // Reset in the middle of a DMA
    bus(16'h4014, 1'b1, 8'h02);
    dma_watch(100, h, w);
    check("dma_rst_writes_before", w, 100);
    rst = 1'b0;
    #1;
    check("dma_rst_halt_drop", cpu_halt, 1'b0);
    check("dma_rst_no_wr", ppu_wr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      addr = 16'h6000; we = 1'b0;
      @(negedge clk);
      if (ppu_wr || cpu_halt) extra++;
      @(posedge clk); #1;
    end
    check("dma_rst_quiet", extra, 0);
    bus(16'h0203, 1'b0, 8'h00);
    check("dma_rst_ram_0203", d_in, 8'h03);
    bus(16'h0010, 1'b0, 8'h00);
    check("dma_rst_ram_0010", d_in, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nes_cpu_bus.md
Name: nes_cpu_bus

Overview:
- CPU-side bus responder for the NES core; the target end of the CPU's addr/d_out/d_in interface.
- Decodes every CPU cycle, serves 2 KB internal work RAM (mirrored), and forwards the PPU register window to a PPU port.
- Owns the OAM DMA engine at $4014, which stalls the CPU via cpu_halt while 256 bytes are copied to PPU register 4.

Parameters:
- RAM_ADDR_W, 11, work-RAM address width (2^11 bytes); RAM mirrors across $0000-$1FFF.
- DMA_REG_ADDR, 16'h4014, address whose write starts OAM DMA.
- OAM_REG_IDX, 3'd4, PPU register index targeted by DMA writes.

Ports:
- clk  input  1  system clock; one CPU bus cycle per clk.
- rst  input  1  reset; asynchronous, active-low.
- addr  input  16  CPU address.
- d_out  input  8  CPU write data.
- we  input  1  CPU write strobe (1 = write, 0 = read).
- d_in  output  8  read data to CPU.
- cpu_halt  output  1  stall request; CPU freezes while 1.
- ppu_addr  output  3  PPU register index.
- ppu_wdata  output  8  PPU write data.
- ppu_wr  output  1  one-cycle PPU write strobe.
- ppu_rd  output  1  one-cycle PPU read strobe.
- ppu_rdata  input  8  PPU read data, combinational, valid in the ppu_rd cycle.

Behaviour:
- Reset (rst=0, async):
  - d_in=0, cpu_halt=0, ppu_wr=0, ppu_rd=0, ppu_addr=0, ppu_wdata=0.
  - FSM=IDLE; cycle-parity toggle=0; open-bus latch=0.
  - RAM contents are not cleared.
- Decode, cycle N with cpu_halt=0:
  - $0000-$1FFF: RAM at addr[RAM_ADDR_W-1:0].
  - $2000-$3FFF: PPU register addr[2:0], mirrored every 8 bytes.
  - DMA_REG_ADDR: write-only; reads return unmapped value.
  - All other addresses: unmapped; writes ignored.
- Reads: d_in is registered and valid in cycle N+1. A PPU read pulses ppu_rd in cycle N only; ppu_rdata is captured at the end of N.
- Writes: RAM is written at the end of cycle N. A PPU write drives ppu_wr=1, ppu_addr and ppu_wdata in cycle N only.
- Parity toggle flips every clk. It is used for DMA alignment.
- FSM states IDLE, ALIGN, DRD, DWR:
  - IDLE -> ALIGN on a write to DMA_REG_ADDR; latch page P=d_out and idx=0. cpu_halt=1 from the next cycle.
  - ALIGN: 1 cycle if the trigger cycle was even (parity 0), 2 cycles if odd; then -> DRD.
  - DRD: read source {P, idx}. Pages $00-$1F read RAM with the same mirroring. Any other page reads the unmapped value, with no ppu_rd side effect. Data is held in an internal register. -> DWR.
  - DWR: ppu_wr=1, ppu_addr=OAM_REG_IDX, ppu_wdata=held byte; idx++. If idx was 255 -> IDLE, else -> DRD.
  - Total halt length: 513 cycles (even trigger) or 514 (odd trigger).
  - cpu_halt drops in the cycle after the last DWR.
- While cpu_halt=1: CPU addr/we/d_out are ignored and d_in holds its last value. A further write to DMA_REG_ADDR has no effect.
- The write that triggers DMA is not forwarded anywhere. ppu_wr and ppu_rd are never asserted together.
- Reset mid-DMA: cpu_halt drops immediately (async), no further ppu_wr, FSM=IDLE. Bytes already written to OAM are not undone.
- idx is 8-bit and wraps naturally. DMA always transfers exactly 256 bytes.

Optional Feature:
- Macro OPEN_BUS_EN.
- Defined: the unmapped read value is the open-bus latch. The latch holds the last byte on the data bus: last d_in returned, or last d_out written by the CPU.
- Not defined: unmapped reads return 8'h00 and the latch is not built.
- DMA reads from pages $20-$FF use the same rule.

Test Plan:
- RAM mirroring: write $0005=A5, then read $0805 and $1805 -> d_in=A5 in the cycle after each read address. Read $0006 -> value previously written there.
- PPU write: write $3FFA=12 -> ppu_wr=1 for exactly one cycle with ppu_addr=2, ppu_wdata=12. RAM is unchanged.
- PPU read: read $2002 with ppu_rdata=80 -> ppu_rd=1 for one cycle with ppu_addr=2; d_in=80 next cycle.
- DMA, even trigger: preload $0200+i=i. Write $4014=02 on an even cycle -> cpu_halt=1 for 513 cycles. 256 ppu_wr pulses with ppu_addr=4 and data 00..FF in order, each separated by one DRD cycle. Repeat on an odd cycle -> 514.
- DMA reset: assert rst low after the 100th DMA write -> cpu_halt=0 immediately, no further ppu_wr. After release, a normal RAM read works and RAM data is intact.
- Unmapped read: write $0010=3C, read $0010, then read $5000 -> with OPEN_BUS_EN d_in=3C; without it, d_in=00.
